// File: rtl/arraymul_eight_four.sv
// arraymul_eight_four: exact unsigned 8x4 AND/half-adder/full-adder array multiplier, registered 12-bit product
module arraymul_eight_four (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  A,
  input  logic [3:0]  B,
  output logic [11:0] R
);
  logic [3:0][7:0] w_pp;
  logic [3:0][8:0] w_acc;
  logic [3:1][7:0] w_c;
  logic [11:0]     w_p;
  genvar i, j;
  generate
    for (j = 0; j < 4; j++) begin : g_pp
      for (i = 0; i < 8; i++) begin : g_and
        assign w_pp[j][i] = A[i] & B[j];
      end
    end
    assign w_acc[0] = {1'b0, w_pp[0]};
    // Each row adds pp[j] to the previous running sum shifted right by one; bit 0 retires as a product bit
    for (j = 1; j < 4; j++) begin : g_row
      assign w_acc[j][0] = w_acc[j-1][1] ^ w_pp[j][0];
      assign w_c[j][0]   = w_acc[j-1][1] & w_pp[j][0];
      for (i = 1; i < 8; i++) begin : g_fa
        assign w_acc[j][i] = w_acc[j-1][i+1] ^ w_pp[j][i] ^ w_c[j][i-1];
        assign w_c[j][i]   = (w_acc[j-1][i+1] & w_pp[j][i]) | (w_c[j][i-1] & (w_acc[j-1][i+1] ^ w_pp[j][i]));
      end
      assign w_acc[j][8] = w_c[j][7];
    end
  endgenerate
  assign w_p = {w_acc[3], w_acc[2][0], w_acc[1][0], w_acc[0][0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) R <= '0;
    else     R <= w_p;
endmodule

// File: tb/tb_arraymul_eight_four.sv
// tb_arraymul_eight_four: corners, exhaustive sweep, random pairs, hold and async reset checks against A*B
module tb_arraymul_eight_four;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  A = '0;
  logic [3:0]  B = '0;
  logic [11:0] R;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  arraymul_eight_four dut (.clk(clk), .rst(rst), .A(A), .B(B), .R(R));
  function automatic logic [11:0] ref_mul(input int a, input int b);
    return 12'(a * b);
  endfunction
  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int a, input int b, input string tag);
    A = 8'(a);
    B = 4'(b);
    @(posedge clk);
    @(negedge clk);
    chk(tag, R, ref_mul(a, b));
  endtask
  initial begin
    int ta[9] = '{0, 200, 1, 255, 255, 128, 127, 170, 85};
    int tb[9] = '{9, 0, 15, 1, 15, 8, 15, 5, 10};
    int ra, rb;
    A = 8'd255;
    B = 4'd15;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", R, 12'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_release", R, 12'd3825);
    for (int k = 0; k < 9; k++) step(ta[k], tb[k], "corner");
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++) begin
        step(a, b, "sweep");
        if (a == 100 && b == 7) begin
          #2 rst = 1'b1;
          #1 chk("mid_rst_async", R, 12'd0);
          @(posedge clk);
          @(negedge clk);
          chk("mid_rst_hold", R, 12'd0);
          rst = 1'b0;
        end
      end
    repeat (300) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 15));
      step(ra, rb, "random");
      A = 8'($urandom);
      B = 4'($urandom);
      #2 chk("between_edges", R, ref_mul(ra, rb));
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
